// File: rtl/sq_pkg.sv
// Shared types for the store queue: store-type encodings, queue entry layout,
// drain FSM states and the enqueue-time formatting helpers.
package sq_pkg;

  localparam logic [2:0] ST_BYTE = 3'b001;
  localparam logic [2:0] ST_HALF = 3'b010;
  localparam logic [2:0] ST_WORD = 3'b100;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } sq_entry_t;

  typedef enum logic {
    SQ_IDLE,
    SQ_REQ
  } sq_state_t;

  function automatic logic [3:0] fmt_mask(input logic [2:0] st_type, input logic [1:0] off);
    case (st_type)
      ST_BYTE: return 4'b0001 << off;
      ST_HALF: return off[1] ? 4'b1100 : 4'b0011;
      ST_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] fmt_data(input logic [2:0] st_type, input logic [31:0] value);
    case (st_type)
      ST_BYTE: return {4{value[7:0]}};
      ST_HALF: return {2{value[15:0]}};
      default: return value;
    endcase
  endfunction

endpackage

// File: rtl/store_queue_if.sv
// Pipeline store path and D-side write port of the store queue.
// SQ_LOAD_FWD_EN adds the load-conflict lookup signals.
interface store_queue_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [2:0]  st_type;
  logic [31:0] st_value;
  logic        st_misalign;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        sq_empty;
`ifdef SQ_LOAD_FWD_EN
  logic [31:0] ld_addr;
  logic        ld_conflict;
`endif

  modport slave (
    input  st_valid, st_addr, st_type, st_value, mem_ack,
    output st_ready, st_misalign, mem_req, mem_addr, mem_wmask, mem_wdata, sq_empty
`ifdef SQ_LOAD_FWD_EN
    , input ld_addr, output ld_conflict
`endif
  );

  modport master (
    output st_valid, st_addr, st_type, st_value, mem_ack,
    input  st_ready, st_misalign, mem_req, mem_addr, mem_wmask, mem_wdata, sq_empty
`ifdef SQ_LOAD_FWD_EN
    , output ld_addr, input ld_conflict
`endif
  );
endinterface

// File: rtl/sq_fifo.sv
// In-order entry storage for the store queue: circular buffer with count.
// SQ_LOAD_FWD_EN exposes the raw entries and read pointer for the load compare.
module sq_fifo
  import sq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  sq_entry_t                push_data,
  input  logic                     pop,
  output sq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef SQ_LOAD_FWD_EN
  ,
  output sq_entry_t                entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0] rd_ptr
`endif
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sq_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
`ifndef SQ_LOAD_FWD_EN
  logic [PW-1:0] rd_ptr;
`else
  assign entries = mem;
`endif

  // Payload storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/store_queue.sv
// Store queue: formats committed stores and drains them in order over req/ack.
// Optional feature macro: SQ_LOAD_FWD_EN (load address conflict detection).
module store_queue
  import sq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  store_queue_if.slave sq
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sq_entry_t     new_entry;
  sq_entry_t     head;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          misalign;
  logic          req;
  sq_state_t     state;
  sq_state_t     state_nxt;
`ifdef SQ_LOAD_FWD_EN
  sq_entry_t     entries [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] slot;
  logic          ld_hit;
`endif

  assign misalign = sq.st_valid &
                    ((sq.st_type[1] & sq.st_addr[0]) |
                     (sq.st_type[2] & (sq.st_addr[1:0] != 2'b00)));
  assign sq.st_misalign = misalign;
  // Ready depends on registered count only, so an ack never opens a full queue.
  assign sq.st_ready = ~full;
  assign push        = sq.st_valid & ~full & ~misalign;
  assign pop         = (state == SQ_REQ) & sq.mem_ack;
  assign count_nxt   = count + CW'(push) - CW'(pop);

  assign new_entry = '{addr:  sq.st_addr[31:2],
                       wmask: fmt_mask(sq.st_type, sq.st_addr[1:0]),
                       wdata: fmt_data(sq.st_type, sq.st_value)};

  sq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(new_entry),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
`ifdef SQ_LOAD_FWD_EN
    ,
    .entries  (entries),
    .rd_ptr   (rd_ptr)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SQ_IDLE;
    else       state <= state_nxt;
  end

  // IDLE looks at the post-update count so a store enqueued now is requested next cycle.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      SQ_IDLE: if (count_nxt != '0) state_nxt = SQ_REQ;
      SQ_REQ: begin
        req = 1'b1;
        if (pop && (count_nxt == '0)) state_nxt = SQ_IDLE;
      end
      default: state_nxt = SQ_IDLE;
    endcase
  end

  assign sq.mem_req   = req;
  assign sq.mem_addr  = req ? {head.addr, 2'b00} : '0;
  assign sq.mem_wmask = req ? head.wmask : '0;
  assign sq.mem_wdata = req ? head.wdata : '0;
  assign sq.sq_empty  = empty;

`ifdef SQ_LOAD_FWD_EN
  always_comb begin
    ld_hit = 1'b0;
    slot   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (entries[slot].addr == sq.ld_addr[31:2]) &&
          (entries[slot].wmask != '0))
        ld_hit = 1'b1;
    end
  end
  assign sq.ld_conflict = ld_hit;
`endif

endmodule
